// File: rtl/regfile_write_arbiter_if.sv
// Write-side bundle between the pipelines, late producers and the register file.
// The arbiter connects through slave; pipelines, producers and the register file model use master.
interface regfile_write_arbiter_if;
    logic        pipe_a_wen;
    logic [4:0]  pipe_a_waddr;
    logic [31:0] pipe_a_wdata;
    logic        pipe_b_wen;
    logic [4:0]  pipe_b_waddr;
    logic [31:0] pipe_b_wdata;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_waddr;
    logic [31:0] md_wdata;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_waddr;
    logic [31:0] ld_wdata;
    logic        stall_req;
    logic        busy;
    logic        wen1_a;
    logic [4:0]  waddr1_a;
    logic [31:0] wdata1_a;
    logic        wen2_a;
    logic [4:0]  waddr2_a;
    logic [31:0] wdata2_a;

    modport slave (
        input  pipe_a_wen, pipe_a_waddr, pipe_a_wdata,
        input  pipe_b_wen, pipe_b_waddr, pipe_b_wdata,
        input  md_valid, md_waddr, md_wdata,
        input  ld_valid, ld_waddr, ld_wdata,
        output md_ready, ld_ready, stall_req, busy,
        output wen1_a, waddr1_a, wdata1_a,
        output wen2_a, waddr2_a, wdata2_a
    );

    modport master (
        output pipe_a_wen, pipe_a_waddr, pipe_a_wdata,
        output pipe_b_wen, pipe_b_waddr, pipe_b_wdata,
        output md_valid, md_waddr, md_wdata,
        output ld_valid, ld_waddr, ld_wdata,
        input  md_ready, ld_ready, stall_req, busy,
        input  wen1_a, waddr1_a, wdata1_a,
        input  wen2_a, waddr2_a, wdata2_a
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Merges two in-order pipeline writes and two one-entry late producers onto the two register file write ports.
// 1-cycle registered latency; pipelines never stall, late producers wait on ready and force drain via stall_req.
module regfile_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_write_arbiter_if.slave  bus
);
    localparam logic [0:0] RR_MD = 1'b0;
    localparam logic [0:0] RR_LD = 1'b1;

    logic        md_held_q, md_held_d, ld_held_q, ld_held_d;
    logic [4:0]  md_addr_q, md_addr_d, ld_addr_q, ld_addr_d;
    logic [31:0] md_data_q, md_data_d, ld_data_q, ld_data_d;
    logic [3:0]  md_age_q, md_age_d, ld_age_q, ld_age_d;
    logic [0:0]  rr_q, rr_d;
    logic        stall_q, stall_d, busy_q, busy_d;
    logic        wen1_q, wen1_d, wen2_q, wen2_d;
    logic [4:0]  waddr1_q, waddr1_d, waddr2_q, waddr2_d;
    logic [31:0] wdata1_q, wdata1_d, wdata2_q, wdata2_d;

    logic free1, free2, md_sq, ld_sq, md_elig, ld_elig, same_addr;
    logic first_is_ld, first_elig, second_elig, first_gnt, second_gnt;
    logic first_port2, second_port2, md_gnt, ld_gnt, md_port2, ld_port2;
    logic md_clear, ld_clear, md_cap, ld_cap;

    always_comb begin
        free1 = !bus.pipe_a_wen;
        free2 = !bus.pipe_b_wen;
        // A same-cycle pipeline write to the held register is younger, so the held value is dead.
        md_sq = md_held_q && ((bus.pipe_a_wen && (bus.pipe_a_waddr == md_addr_q)) ||
                              (bus.pipe_b_wen && (bus.pipe_b_waddr == md_addr_q)));
        ld_sq = ld_held_q && ((bus.pipe_a_wen && (bus.pipe_a_waddr == ld_addr_q)) ||
                              (bus.pipe_b_wen && (bus.pipe_b_waddr == ld_addr_q)));
        md_elig   = md_held_q && !md_sq;
        ld_elig   = ld_held_q && !ld_sq;
        same_addr = md_elig && ld_elig && (md_addr_q == ld_addr_q);

        first_is_ld  = (rr_q == RR_LD);
        first_elig   = first_is_ld ? ld_elig : md_elig;
        second_elig  = (first_is_ld ? md_elig : ld_elig) && !same_addr;
        first_gnt    = first_elig && (free1 || free2);
        first_port2  = !free1;
        second_gnt   = second_elig && (first_gnt ? (free1 && free2) : (free1 || free2));
        second_port2 = first_gnt || !free1;

        md_gnt   = first_is_ld ? second_gnt   : first_gnt;
        md_port2 = first_is_ld ? second_port2 : first_port2;
        ld_gnt   = first_is_ld ? first_gnt    : second_gnt;
        ld_port2 = first_is_ld ? first_port2  : second_port2;
    end

    always_comb begin
        wen1_d   = 1'b0;
        waddr1_d = 5'd0;
        wdata1_d = 32'd0;
        if (bus.pipe_a_wen) begin
            wen1_d   = 1'b1;
            waddr1_d = bus.pipe_a_waddr;
            wdata1_d = bus.pipe_a_wdata;
        end else if (md_gnt && !md_port2) begin
            wen1_d   = 1'b1;
            waddr1_d = md_addr_q;
            wdata1_d = md_data_q;
        end else if (ld_gnt && !ld_port2) begin
            wen1_d   = 1'b1;
            waddr1_d = ld_addr_q;
            wdata1_d = ld_data_q;
        end

        wen2_d   = 1'b0;
        waddr2_d = 5'd0;
        wdata2_d = 32'd0;
        if (bus.pipe_b_wen) begin
            wen2_d   = 1'b1;
            waddr2_d = bus.pipe_b_waddr;
            wdata2_d = bus.pipe_b_wdata;
        end else if (md_gnt && md_port2) begin
            wen2_d   = 1'b1;
            waddr2_d = md_addr_q;
            wdata2_d = md_data_q;
        end else if (ld_gnt && ld_port2) begin
            wen2_d   = 1'b1;
            waddr2_d = ld_addr_q;
            wdata2_d = ld_data_q;
        end
    end

    always_comb begin
        md_clear = md_sq || md_gnt;
        ld_clear = ld_sq || ld_gnt;
        md_cap   = bus.md_valid && !md_held_q;
        ld_cap   = bus.ld_valid && !ld_held_q;

        // Writes to r0 are acknowledged but never occupy the slot.
        md_held_d = md_held_q ? !md_clear : (md_cap && (bus.md_waddr != 5'd0));
        ld_held_d = ld_held_q ? !ld_clear : (ld_cap && (bus.ld_waddr != 5'd0));
        md_addr_d = md_cap ? bus.md_waddr : md_addr_q;
        md_data_d = md_cap ? bus.md_wdata : md_data_q;
        ld_addr_d = ld_cap ? bus.ld_waddr : ld_addr_q;
        ld_data_d = ld_cap ? bus.ld_wdata : ld_data_q;

        md_age_d = 4'd0;
        if (md_held_q && !md_clear)
            md_age_d = (md_age_q == 4'd15) ? md_age_q : md_age_q + 4'd1;
        ld_age_d = 4'd0;
        if (ld_held_q && !ld_clear)
            ld_age_d = (ld_age_q == 4'd15) ? ld_age_q : ld_age_q + 4'd1;

        rr_d = rr_q;
        if (md_elig && ld_elig && (md_gnt ^ ld_gnt))
            rr_d = md_gnt ? RR_LD : RR_MD;

        stall_d = (md_age_d >= 4'(STARVE_LIMIT)) || (ld_age_d >= 4'(STARVE_LIMIT));
        busy_d  = md_held_d || ld_held_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_held_q <= 1'b0;
            ld_held_q <= 1'b0;
            md_addr_q <= 5'd0;
            ld_addr_q <= 5'd0;
            md_data_q <= 32'd0;
            ld_data_q <= 32'd0;
            md_age_q  <= 4'd0;
            ld_age_q  <= 4'd0;
            rr_q      <= RR_MD;
            stall_q   <= 1'b0;
            busy_q    <= 1'b0;
            wen1_q    <= 1'b0;
            waddr1_q  <= 5'd0;
            wdata1_q  <= 32'd0;
            wen2_q    <= 1'b0;
            waddr2_q  <= 5'd0;
            wdata2_q  <= 32'd0;
        end else begin
            md_held_q <= md_held_d;
            ld_held_q <= ld_held_d;
            md_addr_q <= md_addr_d;
            ld_addr_q <= ld_addr_d;
            md_data_q <= md_data_d;
            ld_data_q <= ld_data_d;
            md_age_q  <= md_age_d;
            ld_age_q  <= ld_age_d;
            rr_q      <= rr_d;
            stall_q   <= stall_d;
            busy_q    <= busy_d;
            wen1_q    <= wen1_d;
            waddr1_q  <= waddr1_d;
            wdata1_q  <= wdata1_d;
            wen2_q    <= wen2_d;
            waddr2_q  <= waddr2_d;
            wdata2_q  <= wdata2_d;
        end
    end

    assign bus.md_ready  = !md_held_q;
    assign bus.ld_ready  = !ld_held_q;
    assign bus.stall_req = stall_q;
    assign bus.busy      = busy_q;
    assign bus.wen1_a    = wen1_q;
    assign bus.waddr1_a  = waddr1_q;
    assign bus.wdata1_a  = wdata1_q;
    assign bus.wen2_a    = wen2_q;
    assign bus.waddr2_a  = waddr2_q;
    assign bus.wdata2_a  = wdata2_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations per scenario.
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    regfile_write_arbiter_if bus();

    regfile_write_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.pipe_a_wen = 1'b0; bus.pipe_a_waddr = 5'd0; bus.pipe_a_wdata = 32'd0;
        bus.pipe_b_wen = 1'b0; bus.pipe_b_waddr = 5'd0; bus.pipe_b_wdata = 32'd0;
        bus.md_valid   = 1'b0; bus.md_waddr     = 5'd0; bus.md_wdata     = 32'd0;
        bus.ld_valid   = 1'b0; bus.ld_waddr     = 5'd0; bus.ld_wdata     = 32'd0;
    endtask

    task automatic pipe_a(input logic [4:0] a, input logic [31:0] d);
        bus.pipe_a_wen = 1'b1; bus.pipe_a_waddr = a; bus.pipe_a_wdata = d;
    endtask

    task automatic pipe_b(input logic [4:0] a, input logic [31:0] d);
        bus.pipe_b_wen = 1'b1; bus.pipe_b_waddr = a; bus.pipe_b_wdata = d;
    endtask

    task automatic md(input logic [4:0] a, input logic [31:0] d);
        bus.md_valid = 1'b1; bus.md_waddr = a; bus.md_wdata = d;
    endtask

    task automatic ld(input logic [4:0] a, input logic [31:0] d);
        bus.ld_valid = 1'b1; bus.ld_waddr = a; bus.ld_wdata = d;
    endtask

    task automatic test_reset;
        idle();
        #3;
        checks++;
        if (bus.wen1_a !== 1'b0 || bus.wen2_a !== 1'b0 || bus.waddr1_a !== 5'd0 || bus.wdata1_a !== 32'd0 ||
            bus.waddr2_a !== 5'd0 || bus.wdata2_a !== 32'd0) begin
            errors++;
            $display("FAIL reset_ports: got wen1=%b a1=%0d d1=%h wen2=%b a2=%0d d2=%h, want all 0",
                     bus.wen1_a, bus.waddr1_a, bus.wdata1_a, bus.wen2_a, bus.waddr2_a, bus.wdata2_a);
        end
        checks++;
        if (bus.stall_req !== 1'b0 || bus.busy !== 1'b0 || bus.md_ready !== 1'b1 || bus.ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: got stall=%b busy=%b md_rdy=%b ld_rdy=%b, want 0 0 1 1",
                     bus.stall_req, bus.busy, bus.md_ready, bus.ld_ready);
        end
        #9 rst = 1'b0;
    endtask

    task automatic test_pipe_only;
        idle(); pipe_a(5'd3, 32'h11); pipe_b(5'd4, 32'h22);
        tick();
        checks++;
        if (bus.wen1_a !== 1'b1 || bus.waddr1_a !== 5'd3 || bus.wdata1_a !== 32'h11) begin
            errors++;
            $display("FAIL pipe_port1: got wen=%b a=%0d d=%h, want 1 3 00000011", bus.wen1_a, bus.waddr1_a, bus.wdata1_a);
        end
        checks++;
        if (bus.wen2_a !== 1'b1 || bus.waddr2_a !== 5'd4 || bus.wdata2_a !== 32'h22) begin
            errors++;
            $display("FAIL pipe_port2: got wen=%b a=%0d d=%h, want 1 4 00000022", bus.wen2_a, bus.waddr2_a, bus.wdata2_a);
        end
        checks++;
        if (bus.md_ready !== 1'b1 || bus.ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL pipe_ready: got md=%b ld=%b, want 1 1", bus.md_ready, bus.ld_ready);
        end
        idle();
        tick();
        checks++;
        if (bus.wen1_a !== 1'b0 || bus.wen2_a !== 1'b0) begin
            errors++;
            $display("FAIL pipe_idle: got wen1=%b wen2=%b, want 0 0", bus.wen1_a, bus.wen2_a);
        end
    endtask

    task automatic test_zero_addr;
        idle(); md(5'd0, 32'hDEAD);
        tick();
        idle();
        checks++;
        if (bus.md_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_addr_slot: got md_rdy=%b busy=%b, want 1 0", bus.md_ready, bus.busy);
        end
        tick();
        checks++;
        if (bus.wen1_a !== 1'b0 || bus.wen2_a !== 1'b0) begin
            errors++;
            $display("FAIL zero_addr_write: got wen1=%b wen2=%b, want 0 0", bus.wen1_a, bus.wen2_a);
        end
    endtask

    task automatic test_idle_fill;
        idle(); md(5'd5, 32'hAA);
        tick();
        checks++;
        if (bus.md_ready !== 1'b0 || bus.busy !== 1'b1 || bus.wen1_a !== 1'b0 || bus.wen2_a !== 1'b0) begin
            errors++;
            $display("FAIL fill_capture: got md_rdy=%b busy=%b wen1=%b wen2=%b, want 0 1 0 0",
                     bus.md_ready, bus.busy, bus.wen1_a, bus.wen2_a);
        end
        idle(); pipe_a(5'd1, 32'h10);
        tick();
        checks++;
        if (bus.wen1_a !== 1'b1 || bus.waddr1_a !== 5'd1 || bus.wdata1_a !== 32'h10) begin
            errors++;
            $display("FAIL fill_port1: got wen=%b a=%0d d=%h, want 1 1 00000010", bus.wen1_a, bus.waddr1_a, bus.wdata1_a);
        end
        checks++;
        if (bus.wen2_a !== 1'b1 || bus.waddr2_a !== 5'd5 || bus.wdata2_a !== 32'hAA) begin
            errors++;
            $display("FAIL fill_port2: got wen=%b a=%0d d=%h, want 1 5 000000aa", bus.wen2_a, bus.waddr2_a, bus.wdata2_a);
        end
        checks++;
        if (bus.md_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL fill_drained: got md_rdy=%b busy=%b, want 1 0", bus.md_ready, bus.busy);
        end
        idle();
        tick();
    endtask

    task automatic test_round_robin;
        idle(); md(5'd6, 32'h66); ld(5'd7, 32'h77);
        tick();
        checks++;
        if (bus.md_ready !== 1'b0 || bus.ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL rr_capture: got md_rdy=%b ld_rdy=%b, want 0 0", bus.md_ready, bus.ld_ready);
        end
        idle(); pipe_a(5'd1, 32'h10);
        tick();
        checks++;
        if (bus.wen2_a !== 1'b1 || bus.waddr2_a !== 5'd6 || bus.wdata2_a !== 32'h66) begin
            errors++;
            $display("FAIL rr_first_md: got wen=%b a=%0d d=%h, want 1 6 00000066", bus.wen2_a, bus.waddr2_a, bus.wdata2_a);
        end
        checks++;
        if (bus.md_ready !== 1'b1 || bus.ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL rr_ready_mid: got md_rdy=%b ld_rdy=%b, want 1 0", bus.md_ready, bus.ld_ready);
        end
        tick();
        checks++;
        if (bus.wen2_a !== 1'b1 || bus.waddr2_a !== 5'd7 || bus.wdata2_a !== 32'h77) begin
            errors++;
            $display("FAIL rr_second_ld: got wen=%b a=%0d d=%h, want 1 7 00000077", bus.wen2_a, bus.waddr2_a, bus.wdata2_a);
        end
        // Pointer now favours LD, so LD wins the next contested cycle.
        idle(); md(5'd10, 32'hA0); ld(5'd11, 32'hB0);
        tick();
        idle(); pipe_a(5'd1, 32'h10);
        tick();
        checks++;
        if (bus.wen2_a !== 1'b1 || bus.waddr2_a !== 5'd11 || bus.wdata2_a !== 32'hB0) begin
            errors++;
            $display("FAIL rr_ld_favoured: got wen=%b a=%0d d=%h, want 1 11 000000b0", bus.wen2_a, bus.waddr2_a, bus.wdata2_a);
        end
        tick();
        checks++;
        if (bus.wen2_a !== 1'b1 || bus.waddr2_a !== 5'd10 || bus.wdata2_a !== 32'hA0) begin
            errors++;
            $display("FAIL rr_md_after: got wen=%b a=%0d d=%h, want 1 10 000000a0", bus.wen2_a, bus.waddr2_a, bus.wdata2_a);
        end
        idle();
        tick();
    endtask

    task automatic test_same_addr;
        idle(); md(5'd12, 32'h1); ld(5'd12, 32'h2);
        tick();
        idle();
        tick();
        checks++;
        if (bus.wen1_a !== 1'b1 || bus.waddr1_a !== 5'd12 || bus.wdata1_a !== 32'h1 || bus.wen2_a !== 1'b0) begin
            errors++;
            $display("FAIL same_addr_first: got wen1=%b a1=%0d d1=%h wen2=%b, want 1 12 00000001 0",
                     bus.wen1_a, bus.waddr1_a, bus.wdata1_a, bus.wen2_a);
        end
        tick();
        checks++;
        if (bus.wen1_a !== 1'b1 || bus.waddr1_a !== 5'd12 || bus.wdata1_a !== 32'h2 || bus.wen2_a !== 1'b0) begin
            errors++;
            $display("FAIL same_addr_second: got wen1=%b a1=%0d d1=%h wen2=%b, want 1 12 00000002 0",
                     bus.wen1_a, bus.waddr1_a, bus.wdata1_a, bus.wen2_a);
        end
        tick();
    endtask

    task automatic test_squash;
        idle(); ld(5'd8, 32'h55);
        tick();
        idle(); pipe_b(5'd8, 32'h99);
        tick();
        checks++;
        if (bus.wen2_a !== 1'b1 || bus.waddr2_a !== 5'd8 || bus.wdata2_a !== 32'h99) begin
            errors++;
            $display("FAIL squash_pipe: got wen=%b a=%0d d=%h, want 1 8 00000099", bus.wen2_a, bus.waddr2_a, bus.wdata2_a);
        end
        checks++;
        if (bus.wen1_a !== 1'b0 || bus.ld_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL squash_slot: got wen1=%b d1=%h ld_rdy=%b busy=%b, want 0 - 1 0",
                     bus.wen1_a, bus.wdata1_a, bus.ld_ready, bus.busy);
        end
        idle();
        tick();
        checks++;
        if (bus.wen1_a !== 1'b0 || bus.wen2_a !== 1'b0) begin
            errors++;
            $display("FAIL squash_late: got wen1=%b d1=%h wen2=%b d2=%h, want 0 0",
                     bus.wen1_a, bus.wdata1_a, bus.wen2_a, bus.wdata2_a);
        end
    endtask

    task automatic test_starvation;
        idle(); md(5'd13, 32'hD0);
        tick();
        idle(); pipe_a(5'd1, 32'h1); pipe_b(5'd2, 32'h2);
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (bus.stall_req !== (k >= 4)) begin
                errors++;
                $display("FAIL starve_cycle%0d: got stall=%b, want %b", k, bus.stall_req, (k >= 4));
            end
        end
        checks++;
        if (bus.wen1_a !== 1'b1 || bus.waddr1_a !== 5'd1 || bus.wen2_a !== 1'b1 || bus.waddr2_a !== 5'd2) begin
            errors++;
            $display("FAIL starve_pipes: got a1=%0d a2=%0d, want 1 2", bus.waddr1_a, bus.waddr2_a);
        end
        idle();
        tick();
        checks++;
        if (bus.wen1_a !== 1'b1 || bus.waddr1_a !== 5'd13 || bus.wdata1_a !== 32'hD0 || bus.stall_req !== 1'b0) begin
            errors++;
            $display("FAIL starve_drain: got wen1=%b a1=%0d d1=%h stall=%b, want 1 13 000000d0 0",
                     bus.wen1_a, bus.waddr1_a, bus.wdata1_a, bus.stall_req);
        end
        tick();
    endtask

    task automatic test_reset_hold;
        idle(); md(5'd14, 32'hE0); ld(5'd15, 32'hF0);
        tick();
        idle(); pipe_a(5'd1, 32'h1); pipe_b(5'd2, 32'h2);
        tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.wen1_a !== 1'b1) begin
            errors++;
            $display("FAIL hold_before_rst: got busy=%b wen1=%b, want 1 1", bus.busy, bus.wen1_a);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.wen1_a !== 1'b0 || bus.wen2_a !== 1'b0 || bus.wdata1_a !== 32'd0 || bus.wdata2_a !== 32'd0 ||
            bus.busy !== 1'b0 || bus.md_ready !== 1'b1 || bus.ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_async: got wen1=%b wen2=%b d1=%h d2=%h busy=%b md_rdy=%b ld_rdy=%b, want 0 0 0 0 0 1 1",
                     bus.wen1_a, bus.wen2_a, bus.wdata1_a, bus.wdata2_a, bus.busy, bus.md_ready, bus.ld_ready);
        end
        idle();
        #2 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.wen1_a !== 1'b0 || bus.wen2_a !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_ghost%0d: got wen1=%b wen2=%b busy=%b, want 0 0 0",
                         k, bus.wen1_a, bus.wen2_a, bus.busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pipe_only();
        test_zero_addr();
        test_idle_fill();
        test_round_robin();
        test_same_addr();
        test_squash();
        test_starvation();
        test_reset_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
